// File: rtl/ibis_dvi_pkg.sv
// Shared types and constants for the DVI raster timing generator.
// Default timing is 640x480 @ 800x525 total; control bits map {vsync,hsync}.
package ibis_dvi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  localparam int CTRL_HSYNC_BIT = 0;
  localparam int CTRL_VSYNC_BIT = 1;

  function automatic logic in_window(input logic [11:0] pos,
                                     input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/ibis_dvi_strobe.sv
// Pixel-rate tick divider: one tick every CLK_DIV aclk cycles, forced low and
// re-phased while clr is asserted so the first tick follows clr release.
module ibis_dvi_strobe #(
  parameter int CLK_DIV = 1
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  output logic tick
);

  localparam logic [3:0] CNT_LAST = 4'(CLK_DIV - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else begin
      tick_d = (cnt_q == 4'd0);
      cnt_d  = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // Gate so a tick registered on the last DRAIN cycle never leaks into IDLE.
  assign tick = tick_q & ~clr;

endmodule

// File: rtl/ibis_dvi_timing.sv
// DVI raster timing generator feeding three TMDS encoders.
// Optional IBIS_DVI_FRAME_COUNT_EN adds a 16-bit wrapping frame_count output.
//
// state    | meaning
// ST_IDLE  | raster stopped, counters held at (0,0), no ticks
// ST_RUN   | raster running, run=1
// ST_DRAIN | run dropped; finish the frame, then return to IDLE
module ibis_dvi_timing
  import ibis_dvi_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        run,
  input  logic        px_valid,
  input  logic [23:0] px_data,
  output logic        px_ready,
  output logic        enable,
  output logic        data_enable,
  output logic [1:0]  control,
  output logic [7:0]  data_r,
  output logic [7:0]  data_g,
  output logic [7:0]  data_b,
  output logic [11:0] hpos,
  output logic [11:0] vpos,
  output logic        frame_start,
  output logic        underflow
`ifdef IBIS_DVI_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [1:0]  CTRL_RST = {~SYNC_POL, ~SYNC_POL};

  state_e      state_q, state_d;
  logic [11:0] h_q, h_d, v_q, v_d;
  logic [11:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [23:0] pix_q, pix_d;
  logic [1:0]  control_q, control_d;
  logic        enable_q, enable_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic        uf_q, uf_d;
  logic        tick, active, h_last, v_last;

  ibis_dvi_strobe #(.CLK_DIV(CLK_DIV)) u_strobe (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (state_q == ST_IDLE),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    hpos_d    = hpos_q;
    vpos_d    = vpos_q;
    pix_d     = pix_q;
    control_d = control_q;
    de_d      = de_q;
    uf_d      = uf_q;
    enable_d  = tick;
    fs_d      = 1'b0;
    px_ready  = 1'b0;
    active    = (h_q < H_ACT) && (v_q < V_ACT);
    h_last    = (h_q == H_LAST);
    v_last    = (v_q == V_LAST);

    case (state_q)
      ST_IDLE: begin
        h_d = '0;
        v_d = '0;
        if (run) begin
          state_d = ST_RUN;
          uf_d    = 1'b0;
        end
      end
      ST_RUN:   if (!run) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (run)                           state_d = ST_RUN;
        else if (tick && h_last && v_last) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    // The counters hold the position the next tick presents.
    if (tick) begin
      px_ready  = active;
      hpos_d    = h_q;
      vpos_d    = v_q;
      de_d      = active;
      fs_d      = (h_q == 12'd0) && (v_q == 12'd0);
      pix_d     = (active && px_valid) ? px_data : 24'd0;
      if (active && !px_valid) uf_d = 1'b1;
      control_d[CTRL_HSYNC_BIT] = in_window(h_q, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      control_d[CTRL_VSYNC_BIT] = in_window(v_q, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      h_d = h_last ? 12'd0 : h_q + 12'd1;
      v_d = h_last ? (v_last ? 12'd0 : v_q + 12'd1) : v_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      pix_q     <= '0;
      control_q <= CTRL_RST;
      enable_q  <= 1'b0;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      pix_q     <= pix_d;
      control_q <= control_d;
      enable_q  <= enable_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      uf_q      <= uf_d;
    end
  end

  assign enable      = enable_q;
  assign data_enable = de_q;
  assign control     = control_q;
  assign data_r      = pix_q[23:16];
  assign data_g      = pix_q[15:8];
  assign data_b      = pix_q[7:0];
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

`ifdef IBIS_DVI_FRAME_COUNT_EN
  // Survives IDLE; only reset clears it.
  logic [15:0] fc_q, fc_d;

  always_comb fc_d = fs_d ? fc_q + 16'd1 : fc_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) fc_q <= '0;
    else          fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_ibis_dvi_timing.sv
// Directed bench for ibis_dvi_timing using a shrunken 15x8 raster (8x4 active)
// so whole frames fit in a short run; a second instance covers CLK_DIV=4.
module tb_ibis_dvi_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic [23:0] PIX = 24'hA1B2C3;

  logic aclk = 1'b0, aresetn = 1'b0, run1 = 1'b0, run4 = 1'b0, px_valid = 1'b1;
  logic [23:0] px_data = PIX;

  logic px_ready1, enable1, de1, fs1, uf1;
  logic [1:0] control1;
  logic [7:0] r1, g1, b1;
  logic [11:0] hpos1, vpos1;
  logic px_ready4, enable4, de4, fs4, uf4;
  logic [1:0] control4;
  logic [7:0] r4, g4, b4;
  logic [11:0] hpos4, vpos4;
`ifdef IBIS_DVI_FRAME_COUNT_EN
  logic [15:0] fc1, fc4;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  ibis_dvi_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .CLK_DIV(1)
  ) dut1 (
    .aclk(aclk), .aresetn(aresetn), .run(run1), .px_valid(px_valid), .px_data(px_data),
    .px_ready(px_ready1), .enable(enable1), .data_enable(de1), .control(control1),
    .data_r(r1), .data_g(g1), .data_b(b1), .hpos(hpos1), .vpos(vpos1),
    .frame_start(fs1), .underflow(uf1)
`ifdef IBIS_DVI_FRAME_COUNT_EN
    , .frame_count(fc1)
`endif
  );

  ibis_dvi_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0), .CLK_DIV(4)
  ) dut4 (
    .aclk(aclk), .aresetn(aresetn), .run(run4), .px_valid(px_valid), .px_data(px_data),
    .px_ready(px_ready4), .enable(enable4), .data_enable(de4), .control(control4),
    .data_r(r4), .data_g(g4), .data_b(b4), .hpos(hpos4), .vpos(vpos4),
    .frame_start(fs4), .underflow(uf4)
`ifdef IBIS_DVI_FRAME_COUNT_EN
    , .frame_count(fc4)
`endif
  );

  task automatic wait_pos1(input int h, input int v, output bit found);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (enable1 && hpos1 == 12'(h) && vpos1 == 12'(v)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0; run1 = 1'b0; run4 = 1'b0;
    repeat (2) @(negedge aclk);
    n_checks++; if (enable1 !== 1'b0) begin n_fail++; $display("FAIL rst_enable got %0b want 0", enable1); end
    n_checks++; if (hpos1 !== 12'd0 || vpos1 !== 12'd0) begin n_fail++; $display("FAIL rst_pos got (%0d,%0d) want (0,0)", hpos1, vpos1); end
    n_checks++; if (de1 !== 1'b0) begin n_fail++; $display("FAIL rst_de got %0b want 0", de1); end
    n_checks++; if (control1 !== 2'b11) begin n_fail++; $display("FAIL rst_control got %b want 11", control1); end
    n_checks++; if ({r1, g1, b1} !== 24'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", {r1, g1, b1}); end
    n_checks++; if (uf1 !== 1'b0 || fs1 !== 1'b0 || px_ready1 !== 1'b0) begin n_fail++; $display("FAIL rst_flags got uf=%0b fs=%0b rdy=%0b want 0", uf1, fs1, px_ready1); end
    n_checks++; if (enable4 !== 1'b0 || control4 !== 2'b11) begin n_fail++; $display("FAIL rst_div4 got en=%0b ctl=%b want 0/11", enable4, control4); end
  endtask

  task automatic test_first_enable;
    aresetn = 1'b1; run1 = 1'b1;
    @(negedge aclk);
    n_checks++; if (enable1 !== 1'b0) begin n_fail++; $display("FAIL first_en_c1 got %0b want 0", enable1); end
    @(negedge aclk);
    n_checks++; if (enable1 !== 1'b0 || px_ready1 !== 1'b1) begin n_fail++; $display("FAIL first_en_c2 got en=%0b rdy=%0b want 0/1", enable1, px_ready1); end
    @(negedge aclk);
    n_checks++; if (enable1 !== 1'b1) begin n_fail++; $display("FAIL first_en_c3 got %0b want 1", enable1); end
    n_checks++; if (hpos1 !== 12'd0 || vpos1 !== 12'd0) begin n_fail++; $display("FAIL first_pos got (%0d,%0d) want (0,0)", hpos1, vpos1); end
    n_checks++; if (fs1 !== 1'b1 || de1 !== 1'b1) begin n_fail++; $display("FAIL first_flags got fs=%0b de=%0b want 1/1", fs1, de1); end
    n_checks++; if ({r1, g1, b1} !== PIX) begin n_fail++; $display("FAIL first_data got %h want %h", {r1, g1, b1}, PIX); end
  endtask

  task automatic test_full_frame;
    int eh, ev, en_cnt, de_cnt;
    logic [1:0] ctl_exp;
    logic de_exp;
    eh = 1; ev = 0; en_cnt = 0; de_cnt = 0;
    for (int c = 0; c < HT * VT; c++) begin
      @(negedge aclk);
      n_checks++; if (enable1 !== 1'b1) begin n_fail++; $display("FAIL frame_en_cont cyc %0d got %0b want 1", c, enable1); end
      if (enable1) begin
        en_cnt++;
        if (de1) de_cnt++;
        de_exp = (eh < HA) && (ev < VA);
        ctl_exp[1] = (ev >= VA + VF && ev < VA + VF + VS) ? 1'b0 : 1'b1;
        ctl_exp[0] = (eh >= HA + HF && eh < HA + HF + HS) ? 1'b0 : 1'b1;
        n_checks++; if (hpos1 !== 12'(eh) || vpos1 !== 12'(ev)) begin n_fail++; $display("FAIL frame_pos got (%0d,%0d) want (%0d,%0d)", hpos1, vpos1, eh, ev); end
        n_checks++; if (de1 !== de_exp) begin n_fail++; $display("FAIL frame_de at (%0d,%0d) got %0b want %0b", eh, ev, de1, de_exp); end
        n_checks++; if (control1 !== ctl_exp) begin n_fail++; $display("FAIL frame_ctl at (%0d,%0d) got %b want %b", eh, ev, control1, ctl_exp); end
        n_checks++; if ({r1, g1, b1} !== (de_exp ? PIX : 24'd0)) begin n_fail++; $display("FAIL frame_data at (%0d,%0d) got %h", eh, ev, {r1, g1, b1}); end
        n_checks++; if (fs1 !== (eh == 0 && ev == 0)) begin n_fail++; $display("FAIL frame_fs at (%0d,%0d) got %0b", eh, ev, fs1); end
      end
      if (eh == HT - 1) begin eh = 0; ev = (ev == VT - 1) ? 0 : ev + 1; end
      else eh++;
    end
    n_checks++; if (en_cnt != HT * VT) begin n_fail++; $display("FAIL frame_enables got %0d want %0d", en_cnt, HT * VT); end
    n_checks++; if (de_cnt != HA * VA) begin n_fail++; $display("FAIL frame_active got %0d want %0d", de_cnt, HA * VA); end
  endtask

  task automatic test_underflow;
    bit found;
    n_checks++; if (uf1 !== 1'b0) begin n_fail++; $display("FAIL uf_initial got %0b want 0", uf1); end
    wait_pos1(4, 0, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL uf_wait timeout got none want (4,0)"); end
    n_checks++; if (px_ready1 !== 1'b1) begin n_fail++; $display("FAIL uf_ready got %0b want 1", px_ready1); end
    px_valid = 1'b0;
    @(negedge aclk);
    px_valid = 1'b1;
    n_checks++; if (enable1 !== 1'b1 || hpos1 !== 12'd5) begin n_fail++; $display("FAIL uf_pos got en=%0b h=%0d want 1/5", enable1, hpos1); end
    n_checks++; if ({r1, g1, b1} !== 24'd0) begin n_fail++; $display("FAIL uf_data got %h want 0", {r1, g1, b1}); end
    n_checks++; if (uf1 !== 1'b1) begin n_fail++; $display("FAIL uf_set got %0b want 1", uf1); end
    @(negedge aclk);
    n_checks++; if (hpos1 !== 12'd6 || {r1, g1, b1} !== PIX) begin n_fail++; $display("FAIL uf_recover got h=%0d d=%h want 6/%h", hpos1, {r1, g1, b1}, PIX); end
    n_checks++; if (uf1 !== 1'b1) begin n_fail++; $display("FAIL uf_sticky got %0b want 1", uf1); end
  endtask

  task automatic test_drain;
    bit found;
    int en_cnt;
    wait_pos1(3, 2, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL drain_wait timeout got none want (3,2)"); end
    run1 = 1'b0;
    wait_pos1(HT - 1, VT - 1, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL drain_end timeout got none want (%0d,%0d)", HT - 1, VT - 1); end
    en_cnt = 0;
    repeat (20) begin
      @(negedge aclk);
      if (enable1) en_cnt++;
    end
    n_checks++; if (en_cnt != 0) begin n_fail++; $display("FAIL drain_idle got %0d enables want 0", en_cnt); end
    n_checks++; if (uf1 !== 1'b1) begin n_fail++; $display("FAIL drain_uf_idle got %0b want 1", uf1); end
    run1 = 1'b1;
    @(negedge aclk);
    n_checks++; if (uf1 !== 1'b0) begin n_fail++; $display("FAIL drain_uf_clear got %0b want 0", uf1); end
    repeat (2) @(negedge aclk);
    n_checks++; if (enable1 !== 1'b1 || hpos1 !== 12'd0 || vpos1 !== 12'd0 || fs1 !== 1'b1) begin n_fail++; $display("FAIL drain_restart got en=%0b (%0d,%0d) fs=%0b want 1 (0,0) 1", enable1, hpos1, vpos1, fs1); end
  endtask

  task automatic test_div4;
    logic [23:0] d_exp;
    run4 = 1'b1;
    repeat (2) @(negedge aclk);
    n_checks++; if (enable4 !== 1'b0) begin n_fail++; $display("FAIL div4_early got %0b want 0", enable4); end
    @(negedge aclk);
    n_checks++; if (enable4 !== 1'b1 || hpos4 !== 12'd0 || vpos4 !== 12'd0 || fs4 !== 1'b1) begin n_fail++; $display("FAIL div4_first got en=%0b (%0d,%0d) fs=%0b", enable4, hpos4, vpos4, fs4); end
    for (int k = 1; k <= 12; k++) begin
      d_exp = (k - 1 < HA) ? PIX : 24'd0;
      for (int o = 1; o <= 3; o++) begin
        @(negedge aclk);
        n_checks++; if (enable4 !== 1'b0 || hpos4 !== 12'(k - 1) || {r4, g4, b4} !== d_exp) begin n_fail++; $display("FAIL div4_hold k=%0d o=%0d got en=%0b h=%0d d=%h want 0/%0d/%h", k, o, enable4, hpos4, {r4, g4, b4}, k - 1, d_exp); end
      end
      @(negedge aclk);
      d_exp = (k < HA) ? PIX : 24'd0;
      n_checks++; if (enable4 !== 1'b1 || hpos4 !== 12'(k) || {r4, g4, b4} !== d_exp) begin n_fail++; $display("FAIL div4_step k=%0d got en=%0b h=%0d d=%h want 1/%0d/%h", k, enable4, hpos4, {r4, g4, b4}, k, d_exp); end
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    wait_pos1(5, 3, found);
    n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_wait timeout got none want (5,3)"); end
    aresetn = 1'b0;
    @(negedge aclk);
    n_checks++; if (enable1 !== 1'b0 || de1 !== 1'b0 || fs1 !== 1'b0 || px_ready1 !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got en=%0b de=%0b fs=%0b rdy=%0b want 0", enable1, de1, fs1, px_ready1); end
    n_checks++; if (hpos1 !== 12'd0 || vpos1 !== 12'd0) begin n_fail++; $display("FAIL rmid_pos got (%0d,%0d) want (0,0)", hpos1, vpos1); end
    n_checks++; if (control1 !== 2'b11 || {r1, g1, b1} !== 24'd0) begin n_fail++; $display("FAIL rmid_out got ctl=%b d=%h want 11/0", control1, {r1, g1, b1}); end
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    n_checks++; if (enable1 !== 1'b1 || hpos1 !== 12'd0 || vpos1 !== 12'd0 || fs1 !== 1'b1) begin n_fail++; $display("FAIL rmid_restart got en=%0b (%0d,%0d) fs=%0b want 1 (0,0) 1", enable1, hpos1, vpos1, fs1); end
  endtask

  initial begin
    test_reset;
    test_first_enable;
    test_full_frame;
    test_underflow;
    test_drain;
    test_div4;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
